rx_datapath: RTL
================

Name: rx_datapath

Overview:
- Serial-receive datapath driven by the receive `controller`: shifts in serial bits under `count_en`, keeps the received-bit count, and reports "more bits pending" on `comp_out`.
- On `RxReg_ld` it captures the assembled word into the receive register and presents it downstream with a valid/ready handshake.
- Flags overrun when a new word is loaded before the previous one was consumed.

Parameters:
- DATA_WIDTH, 8, bits per received word; legal range 2..32.
- CNT_WIDTH, $clog2(DATA_WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- serial_in  input  1  received serial bit, sampled when `count_en`=1.
- count_en  input  1  from controller: shift `serial_in` in and increment the bit count.
- count_clr  input  1  from controller: clear the bit count.
- RxReg_ld  input  1  from controller: load the shift register into the receive register.
- comp_out  output  1  to controller: 1 while bit_count < DATA_WIDTH.
- rx_data  output  DATA_WIDTH  received word.
- rx_valid  output  1  `rx_data` holds an unconsumed word.
- rx_ready  input  1  downstream accepts the word when `rx_valid`=1 and `rx_ready`=1.
- overrun  output  1  sticky; set when a word is overwritten before being consumed.
- overrun_clr  input  1  synchronous clear of `overrun`.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-high.
- Reset values: shift_reg=0, bit_count=0, rx_data=0, rx_valid=0, overrun=0. `comp_out` is therefore 1 during and after reset.
- Shift:
  - On a rising edge with `count_en`=1, `count_clr`=0 and bit_count<DATA_WIDTH: shift_reg <= {serial_in, shift_reg[DATA_WIDTH-1:1]}. Order is LSB first: the first bit ends in bit 0 after DATA_WIDTH shifts.
  - In the same edge, bit_count increments by 1.
- Saturation: with bit_count==DATA_WIDTH, `count_en` is ignored. No shift, no increment, no wrap.
- Clear:
  - `count_clr`=1 sets bit_count <= 0.
  - `count_clr` has priority over `count_en` in the same cycle; no shift occurs.
  - shift_reg contents are not cleared.
- comp_out:
  - Combinational from the registered count: comp_out = (bit_count != DATA_WIDTH).
  - Falls in the cycle after the DATA_WIDTH-th accepted `count_en` edge; zero additional latency.
- Load: on an edge with `RxReg_ld`=1, rx_data <= shift_reg and rx_valid <= 1. rx_data is visible the cycle after the load; one-cycle latency.
- Handshake:
  - rx_data is stable while rx_valid=1 and no load occurs.
  - rx_valid=1 and rx_ready=1 with no load: rx_valid <= 0 at that edge.
  - `rx_ready` is a don't-care while rx_valid=0.
- Load and handshake in the same cycle:
  - Load with rx_valid=1 and rx_ready=1: new word loaded, rx_valid stays 1, no overrun.
  - Load with rx_valid=1 and rx_ready=0: new word overwrites, rx_valid stays 1, overrun <= 1.
- overrun:
  - Stays set until `overrun_clr` or reset.
  - Set and clear in the same cycle: set wins.
- Load and shift/clear in the same cycle: the load captures the pre-edge shift_reg. Shift and count update in parallel.
- Reset mid-word: all state returns to reset values immediately (asynchronous). Any partial word and any pending rx_valid are discarded.
- No combinational path from any input to any output except through `comp_out` from bit_count.

Decomposition:
- Shared package `rx_pkg`:
  - DATA_WIDTH default constant.
  - Count-width function (clog2(DATA_WIDTH+1)).
  - Bit-count typedef, shared with `controller` and its bench.
- One sub-module `rx_bit_counter`: saturating up-counter with clear priority. Inputs clock, reset, en, clr; outputs count and done (count==DATA_WIDTH). `comp_out` = ~done.
- Shift register, receive register, handshake and overrun logic stay in `rx_datapath`.

Test Plan:
- Reset: hold reset 100 time units -> comp_out=1, rx_valid=0, overrun=0, rx_data=0x00. Assert reset mid-edge -> outputs clear without waiting for a clock.
- Word receive: count_clr 1 cycle, then 8 cycles count_en with serial_in=1,0,1,0,0,1,0,1, then RxReg_ld -> comp_out falls after the 8th edge; rx_data=0xA5, rx_valid=1 the cycle after the load.
- Saturation and priority:
  - After 8 bits, 3 more count_en cycles with serial_in=0 -> shift_reg unchanged, count stays 8, comp_out stays 0.
  - count_en and count_clr together -> count=0, no shift.
- Handshake: load 0x3C, rx_ready=0 for 4 cycles -> rx_data holds 0x3C, rx_valid=1. rx_ready=1 -> rx_valid=0 next cycle.
- Overrun:
  - Load 0x11 and leave it unconsumed, then load 0x22 with rx_ready=0 -> rx_data=0x22, overrun=1.
  - Repeat the second load with rx_ready=1 in the load cycle -> overrun stays 0.
  - overrun_clr with a simultaneous overrun event -> overrun remains 1.

Source files
------------

// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared constants and bit-count type for the receive path
package rx_pkg;

  localparam int RX_DATA_WIDTH = 8;

  function automatic int rx_cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

  localparam int RX_CNT_WIDTH = rx_cnt_width(RX_DATA_WIDTH);

  // Shared with the controller so both sides agree on the count encoding
  typedef logic [RX_CNT_WIDTH-1:0] bit_count_t;

endpackage

// File: rtl/rx_bit_counter.sv
// rtl/rx_bit_counter.sv - saturating received-bit counter, clear has priority
module rx_bit_counter
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = RX_DATA_WIDTH,
  parameter int CNT_WIDTH  = rx_cnt_width(DATA_WIDTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 done
);

  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_done;

  assign w_done = (r_count == CNT_WIDTH'(DATA_WIDTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !w_done) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign done  = w_done;

endmodule

// File: rtl/rx_datapath.sv
// rtl/rx_datapath.sv - serial receive shifter, receive register, handshake and overrun
module rx_datapath
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = RX_DATA_WIDTH,
  localparam int CNT_WIDTH = rx_cnt_width(DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serial_in,
  input  logic                  count_en,
  input  logic                  count_clr,
  input  logic                  RxReg_ld,
  output logic                  comp_out,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  logic [CNT_WIDTH-1:0]  w_count;
  logic                  w_done;
  logic                  w_shift;
  logic                  w_ovr_set;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_overrun;

  rx_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_bit_counter (
    .clock (clock),
    .reset (reset),
    .en    (count_en),
    .clr   (count_clr),
    .count (w_count),
    .done  (w_done)
  );

  assign w_shift   = count_en && !count_clr && !w_done;
  assign w_ovr_set = RxReg_ld && r_rx_valid && !rx_ready;

  // LSB first: the earliest bit walks down to bit 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
    end else if (w_shift) begin
      r_shift <= {serial_in, r_shift[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (RxReg_ld) begin
      r_rx_data  <= r_shift;
      r_rx_valid <= 1'b1;
    end else if (r_rx_valid && rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  // Set beats clear so a simultaneous overwrite is never lost
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign comp_out = ~w_done;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign overrun  = r_overrun;

endmodule
